// File: rtl/gray_decoder_pkg.sv
// Shared definitions for the Gray-counter receive path: FSM encodings and default widths.
// Encoding 2'd3 is never entered; the decoder treats it like ST_EMPTY.
package gray_decoder_pkg;

  localparam int GRAY_WIDTH_DEFAULT = 3;
  localparam int WRAP_W_DEFAULT     = 8;

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_LOCKED = 2'd1;
  localparam logic [1:0] ST_RESYNC = 2'd2;

endpackage

// File: rtl/gray_decoder_if.sv
// Bus between a Gray-counter sample source (master) and the gray_decoder (slave).
// Valid has no ready partner: a sample is taken on every edge where Valid==1, and results appear one cycle later.
interface gray_decoder_if
  import gray_decoder_pkg::*;
#(
  parameter int WIDTH  = GRAY_WIDTH_DEFAULT,
  parameter int WRAP_W = WRAP_W_DEFAULT
);
  logic              Valid;
  logic [WIDTH-1:0]  Gray_in;
  logic              Clr_flags;
  logic [WIDTH-1:0]  Binary;
  logic              Out_valid;
  logic              Step_fwd;
  logic              Step_bwd;
  logic              Jump;
  logic              Overflow;
  logic              Error;
  logic [WRAP_W-1:0] Wrap_count;
  logic [1:0]        State;

  modport master (
    output Valid, Gray_in, Clr_flags,
    input  Binary, Out_valid, Step_fwd, Step_bwd, Jump, Overflow, Error, Wrap_count, State
  );

  modport slave (
    input  Valid, Gray_in, Clr_flags,
    output Binary, Out_valid, Step_fwd, Step_bwd, Jump, Overflow, Error, Wrap_count, State
  );
endinterface

// File: rtl/gray_decoder_gray_to_bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray_to_bin #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_decoder.sv
// Gray word receiver: decodes samples, classifies the step from the previous sample,
// and keeps sticky overflow/error flags plus a saturating forward-wrap counter.
module gray_decoder
  import gray_decoder_pkg::*;
#(
  parameter int WIDTH  = GRAY_WIDTH_DEFAULT,
  parameter int WRAP_W = WRAP_W_DEFAULT
) (
  input  logic           Clk,
  input  logic           Reset,
  gray_decoder_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAXV = '1;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] delta;
  logic             is_fwd;
  logic             is_bwd;
  logic             is_jump;
  logic             is_wrap;

  gray_to_bin #(.WIDTH(WIDTH)) u_g2b (
    .gray (bus.Gray_in),
    .bin  (dec)
  );

  assign delta     = dec - bus.Binary;
  assign bus.State = state;

  // Only a LOCKED sample has a trusted reference; EMPTY/RESYNC samples just reload it.
  always_comb begin
    is_fwd  = 1'b0;
    is_bwd  = 1'b0;
    is_jump = 1'b0;
    is_wrap = 1'b0;
    if (bus.Valid && state == ST_LOCKED) begin
      if (delta == ONE) begin
        is_fwd  = 1'b1;
        is_wrap = (bus.Binary == MAXV);
      end else if (delta == MAXV) begin
        is_bwd  = 1'b1;
      end else if (delta != '0) begin
        is_jump = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state          <= ST_EMPTY;
      bus.Binary     <= '0;
      bus.Out_valid  <= 1'b0;
      bus.Step_fwd   <= 1'b0;
      bus.Step_bwd   <= 1'b0;
      bus.Jump       <= 1'b0;
      bus.Overflow   <= 1'b0;
      bus.Error      <= 1'b0;
      bus.Wrap_count <= '0;
    end else begin
      bus.Out_valid <= bus.Valid;
      bus.Step_fwd  <= is_fwd;
      bus.Step_bwd  <= is_bwd;
      bus.Jump      <= is_jump;

      if (bus.Valid) begin
        bus.Binary <= dec;
        case (state)
          ST_LOCKED: state <= is_jump ? ST_RESYNC : ST_LOCKED;
          ST_RESYNC: state <= ST_LOCKED;
          default:   state <= ST_LOCKED;
        endcase
      end

      // A set event in the same cycle as a clear wins over the clear.
      if (bus.Clr_flags) begin
        bus.Overflow   <= is_wrap;
        bus.Error      <= is_jump;
        bus.Wrap_count <= is_wrap ? WRAP_W'(1) : '0;
      end else begin
        bus.Overflow <= bus.Overflow | is_wrap;
        bus.Error    <= bus.Error | is_jump;
        if (is_wrap && bus.Wrap_count != '1) begin
          bus.Wrap_count <= bus.Wrap_count + WRAP_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_gray_decoder.sv
// Self-checking bench for gray_decoder (WIDTH=3, WRAP_W=8): a reference model pushes the
// expected output word per driven cycle and each scenario task pops and compares it.
module tb_gray_decoder;
  import gray_decoder_pkg::*;

  localparam int W  = 3;
  localparam int WW = 8;
  localparam int OW = W + 6 + WW;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;

  gray_decoder_if #(.WIDTH(W), .WRAP_W(WW)) bus ();

  gray_decoder #(.WIDTH(W), .WRAP_W(WW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  logic [OW-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  logic [1:0]    m_state;
  logic [W-1:0]  m_bin;
  logic          m_ovf;
  logic          m_err;
  logic [WW-1:0] m_wc;

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic acc;
    logic [W-1:0] b;
    acc = 1'b0;
    b   = '0;
    for (int i = W - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

  function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [OW-1:0] obs();
    return {bus.Binary, bus.Out_valid, bus.Step_fwd, bus.Step_bwd, bus.Jump,
            bus.Overflow, bus.Error, bus.Wrap_count};
  endfunction

  // Drive one cycle, push the model's expected output, and return just after the edge.
  task automatic drive(input logic rst, input logic valid, input logic [W-1:0] gray, input logic clr);
    logic [W-1:0] dec;
    logic [W-1:0] d;
    logic sf, sb, jp, wrap;
    Reset         = rst;
    bus.Valid     = valid;
    bus.Gray_in   = gray;
    bus.Clr_flags = clr;
    sf = 1'b0; sb = 1'b0; jp = 1'b0; wrap = 1'b0;
    if (!rst) begin
      m_state = ST_EMPTY;
      m_bin   = '0;
      m_ovf   = 1'b0;
      m_err   = 1'b0;
      m_wc    = '0;
      exp_q.push_back('0);
    end else begin
      if (valid) begin
        dec = g2b(gray);
        d   = dec - m_bin;
        if (m_state == ST_LOCKED) begin
          if (d == 3'd1) begin
            sf   = 1'b1;
            wrap = (m_bin == 3'd7);
          end else if (d == 3'd7) begin
            sb = 1'b1;
          end else if (d != 3'd0) begin
            jp = 1'b1;
          end
        end
        m_state = jp ? ST_RESYNC : ST_LOCKED;
        m_bin   = dec;
      end
      if (clr) begin
        m_ovf = wrap;
        m_err = jp;
        m_wc  = wrap ? 8'd1 : 8'd0;
      end else begin
        m_ovf = m_ovf | wrap;
        m_err = m_err | jp;
        if (wrap && m_wc != 8'hFF) m_wc = m_wc + 8'd1;
      end
      exp_q.push_back({m_bin, valid, sf, sb, jp, m_ovf, m_err, m_wc});
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    logic [OW-1:0] exp, got;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 3'b101, 1'b1);
      exp = exp_q.pop_front(); got = obs(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset[%0d]: got %h expected %h", i, got, exp);
      end
    end
    drive(1'b1, 1'b1, 3'b000, 1'b0);
    exp = exp_q.pop_front(); got = obs(); vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL first_sample: got %h expected %h", got, exp);
    end
    vectors++;
    if (bus.Out_valid !== 1'b1 || bus.Binary !== 3'd0 || bus.Step_fwd !== 1'b0 || bus.Overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL first_sample_direct: got ov=%b bin=%0d fwd=%b ovf=%b expected 1 0 0 0",
               bus.Out_valid, bus.Binary, bus.Step_fwd, bus.Overflow);
    end
  endtask

  task automatic test_forward();
    logic [OW-1:0] exp, got;
    logic [W-1:0] seq [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, seq[i], 1'b0);
      exp = exp_q.pop_front(); got = obs(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL fwd[%0d]: got %h expected %h", i, got, exp);
      end
    end
    vectors++;
    if (bus.Binary !== 3'd0 || bus.Step_fwd !== 1'b1 || bus.Overflow !== 1'b1 || bus.Wrap_count !== 8'd1) begin
      miscompares++;
      $display("FAIL fwd_wrap: got bin=%0d fwd=%b ovf=%b wc=%0d expected 0 1 1 1",
               bus.Binary, bus.Step_fwd, bus.Overflow, bus.Wrap_count);
    end
  endtask

  task automatic test_backward();
    logic [OW-1:0] exp, got;
    logic [W-1:0] seq [5] = '{3'b001, 3'b011, 3'b001, 3'b000, 3'b100};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, seq[i], 1'b0);
      exp = exp_q.pop_front(); got = obs(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL bwd[%0d]: got %h expected %h", i, got, exp);
      end
    end
    vectors++;
    if (bus.Binary !== 3'd7 || bus.Step_bwd !== 1'b1 || bus.Wrap_count !== 8'd1) begin
      miscompares++;
      $display("FAIL bwd_wrap: got bin=%0d bwd=%b wc=%0d expected 7 1 1",
               bus.Binary, bus.Step_bwd, bus.Wrap_count);
    end
  endtask

  task automatic test_jump();
    logic [OW-1:0] exp, got;
    logic [W-1:0] seq [5] = '{3'b000, 3'b001, 3'b110, 3'b111, 3'b101};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, seq[i], 1'b0);
      exp = exp_q.pop_front(); got = obs(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL jump[%0d]: got %h expected %h", i, got, exp);
      end
      if (i == 2) begin
        vectors++;
        if (bus.Jump !== 1'b1 || bus.Error !== 1'b1 || bus.Binary !== 3'd4) begin
          miscompares++;
          $display("FAIL jump_direct: got jump=%b err=%b bin=%0d expected 1 1 4",
                   bus.Jump, bus.Error, bus.Binary);
        end
      end
    end
  endtask

  task automatic test_clr_flags();
    logic [OW-1:0] exp, got;
    drive(1'b1, 1'b1, 3'b100, 1'b0);
    exp = exp_q.pop_front(); got = obs(); vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL clr_pre: got %h expected %h", got, exp);
    end
    drive(1'b1, 1'b1, 3'b000, 1'b1);
    exp = exp_q.pop_front(); got = obs(); vectors++;
    if (got !== exp || bus.Overflow !== 1'b1 || bus.Wrap_count !== 8'd1 || bus.Error !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_with_wrap: got %h expected %h", got, exp);
    end
    drive(1'b1, 1'b0, 3'b111, 1'b1);
    exp = exp_q.pop_front(); got = obs(); vectors++;
    if (got !== exp || bus.Overflow !== 1'b0 || bus.Binary !== 3'd0 || bus.Out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_alone: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [OW-1:0] exp, got;
    drive(1'b1, 1'b1, 3'b111, 1'b0);
    exp = exp_q.pop_front(); got = obs(); vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL mid_pre: got %h expected %h", got, exp);
    end
    drive(1'b0, 1'b1, 3'b011, 1'b0);
    exp = exp_q.pop_front(); got = obs(); vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL mid_reset: got %h expected %h", got, exp);
    end
    drive(1'b1, 1'b1, 3'b100, 1'b0);
    exp = exp_q.pop_front(); got = obs(); vectors++;
    if (got !== exp || bus.Binary !== 3'd7 || bus.Jump !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_release: got %h expected %h", got, exp);
    end
    for (int n = 0; n < 256; n++) begin
      for (int b = 0; b < 8; b++) begin
        drive(1'b1, 1'b1, b2g(3'(b)), 1'b0);
        exp = exp_q.pop_front(); got = obs(); vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL sat[%0d.%0d]: got %h expected %h", n, b, got, exp);
        end
      end
    end
    vectors++;
    if (bus.Wrap_count !== 8'hFF || bus.Overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_final: got wc=%0d ovf=%b expected 255 1", bus.Wrap_count, bus.Overflow);
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] exp, got;
    logic [W-1:0] b;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       b = m_bin + 3'd1;
        1:       b = m_bin - 3'd1;
        2:       b = m_bin;
        default: b = 3'($urandom_range(0, 7));
      endcase
      drive($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0, b2g(b), $urandom_range(0, 15) == 0);
      exp = exp_q.pop_front(); got = obs(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL rand[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  initial begin
    bus.Valid     = 1'b0;
    bus.Gray_in   = '0;
    bus.Clr_flags = 1'b0;
    m_state = ST_EMPTY; m_bin = '0; m_ovf = 1'b0; m_err = 1'b0; m_wc = '0;
    #2;
    test_reset();
    test_forward();
    test_backward();
    test_jump();
    test_clr_flags();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
